// File: rtl/mips_ctrl_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Package     : mips_ctrl_pkg
//  Description : Opcodes, state encoding and control-field encodings shared
//                by the multi-cycle MIPS controller and its decoder.
//  Revision    : 1.0  initial release
// ============================================================================
package mips_ctrl_pkg;

    localparam logic [5:0] OPC_R    = 6'b000000;
    localparam logic [5:0] OPC_LW   = 6'b100011;
    localparam logic [5:0] OPC_SW   = 6'b101011;
    localparam logic [5:0] OPC_BEQ  = 6'b000100;
    localparam logic [5:0] OPC_BNE  = 6'b000101;
    localparam logic [5:0] OPC_J    = 6'b000010;
    localparam logic [5:0] OPC_JAL  = 6'b000011;
    localparam logic [5:0] OPC_ADDI = 6'b001000;
    localparam logic [5:0] OPC_SLTI = 6'b001010;

    // All sixteen codes are used; FETCH must stay at zero.
    typedef enum logic [3:0] {
        ST_FETCH     = 4'd0,
        ST_DECODE    = 4'd1,
        ST_MEM_ADDR  = 4'd2,
        ST_MEM_READ  = 4'd3,
        ST_MEM_WB    = 4'd4,
        ST_MEM_WRITE = 4'd5,
        ST_R_EX      = 4'd6,
        ST_R_WB      = 4'd7,
        ST_BEQ       = 4'd8,
        ST_BNE       = 4'd9,
        ST_JUMP      = 4'd10,
        ST_JAL       = 4'd11,
        ST_ADDI_EX   = 4'd12,
        ST_SLTI_EX   = 4'd13,
        ST_I_WB      = 4'd14,
        ST_NOP       = 4'd15
    } state_t;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10,
        ALUOP_SLT   = 2'b11
    } aluop_t;

    typedef enum logic [1:0] {
        SRCB_B      = 2'b00,
        SRCB_FOUR   = 2'b01,
        SRCB_IMM    = 2'b10,
        SRCB_IMM_SH = 2'b11
    } alusrcb_t;

    typedef enum logic [1:0] {
        PCSRC_ALU    = 2'b00,
        PCSRC_ALUOUT = 2'b01,
        PCSRC_JUMP   = 2'b10,
        PCSRC_RSVD   = 2'b11
    } pcsrc_t;

    typedef struct packed {
        logic     pc_write;
        logic     pc_write_beq;
        logic     pc_write_bne;
        logic     i_or_d;
        logic     ir_write;
        logic     mem_read;
        logic     mem_write;
        logic     reg_write;
        logic     reg_dst;
        logic     jal_sig1;
        logic     jal_sig2;
        logic     mem_to_reg;
        logic     alu_src_a;
        alusrcb_t alu_src_b;
        aluop_t   alu_op;
        pcsrc_t   pc_src;
        logic     done;
    } ctrl_t;

endpackage
`default_nettype wire

// File: rtl/mc_control_fsm_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Interface   : mc_control_fsm_if
//  Description : Datapath/controller boundary: opcode in, control strobes out.
//  Revision    : 1.0  initial release
// ============================================================================
interface mc_control_fsm_if;
    logic [5:0] opc;
    logic       PCWrite;
    logic       PCWriteCondBeq;
    logic       PCWriteCondBne;
    logic       IorD;
    logic       IRWrite;
    logic       MemRead;
    logic       MemWrite;
    logic       RegWrite;
    logic       RegDst;
    logic       JalSig1;
    logic       JalSig2;
    logic       MemToReg;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic [1:0] PCSrc;
    logic       done;

    // Controller side
    modport master (
        input  opc,
        output PCWrite, PCWriteCondBeq, PCWriteCondBne, IorD, IRWrite,
               MemRead, MemWrite, RegWrite, RegDst, JalSig1, JalSig2,
               MemToReg, ALUSrcA, ALUSrcB, ALUOp, PCSrc, done
    );

    // Datapath side
    modport slave (
        output opc,
        input  PCWrite, PCWriteCondBeq, PCWriteCondBne, IorD, IRWrite,
               MemRead, MemWrite, RegWrite, RegDst, JalSig1, JalSig2,
               MemToReg, ALUSrcA, ALUSrcB, ALUOp, PCSrc, done
    );
endinterface
`default_nettype wire

// File: rtl/mc_ctrl_outdec.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : mc_ctrl_outdec
//  Description : Pure state-to-controls decoder (Moore outputs of the FSM).
//  Revision    : 1.0  initial release
// ============================================================================
module mc_ctrl_outdec
    import mips_ctrl_pkg::*;
(
    input  state_t state,
    output ctrl_t  ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            ST_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.ir_write  = 1'b1;
                ctrl.pc_write  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
            end
            // Branch target computed speculatively into ALUOut.
            ST_DECODE: ctrl.alu_src_b = SRCB_IMM_SH;
            ST_MEM_ADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
            end
            ST_MEM_READ: begin
                ctrl.i_or_d   = 1'b1;
                ctrl.mem_read = 1'b1;
            end
            ST_MEM_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.done       = 1'b1;
            end
            ST_MEM_WRITE: begin
                ctrl.i_or_d    = 1'b1;
                ctrl.mem_write = 1'b1;
                ctrl.done      = 1'b1;
            end
            ST_R_EX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            ST_R_WB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
                ctrl.done      = 1'b1;
            end
            ST_BEQ, ST_BNE: begin
                ctrl.alu_src_a    = 1'b1;
                ctrl.alu_op       = ALUOP_SUB;
                ctrl.pc_src       = PCSRC_ALUOUT;
                ctrl.pc_write_beq = (state == ST_BEQ);
                ctrl.pc_write_bne = (state == ST_BNE);
                ctrl.done         = 1'b1;
            end
            ST_JUMP: begin
                ctrl.pc_write = 1'b1;
                ctrl.pc_src   = PCSRC_JUMP;
                ctrl.done     = 1'b1;
            end
            // PC already holds PC+4, so the link write lands with the jump.
            ST_JAL: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_src    = PCSRC_JUMP;
                ctrl.reg_write = 1'b1;
                ctrl.jal_sig1  = 1'b1;
                ctrl.jal_sig2  = 1'b1;
                ctrl.done      = 1'b1;
            end
            ST_ADDI_EX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            ST_SLTI_EX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_SLT;
            end
            ST_I_WB: begin
                ctrl.reg_write = 1'b1;
                ctrl.done      = 1'b1;
            end
            ST_NOP: ctrl.done = 1'b1;
            default: ctrl = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mc_control_fsm.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : mc_control_fsm
//  Description : Multi-cycle MIPS controller: state register, next-state logic
//                and Moore output decode driving the datapath interface.
//  Revision    : 1.0  initial release
// ============================================================================
module mc_control_fsm
    import mips_ctrl_pkg::*;
(
    input  wire logic          clk,
    input  wire logic          rst,
    mc_control_fsm_if.master   bus
);

    state_t state_q;
    state_t state_d;
    ctrl_t  ctrl;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // opc only steers next-state, never the outputs.
    always_comb begin
        state_d = ST_FETCH;
        case (state_q)
            ST_FETCH: state_d = ST_DECODE;
            ST_DECODE: begin
                case (bus.opc)
                    OPC_LW, OPC_SW: state_d = ST_MEM_ADDR;
                    OPC_R:          state_d = ST_R_EX;
                    OPC_BEQ:        state_d = ST_BEQ;
                    OPC_BNE:        state_d = ST_BNE;
                    OPC_J:          state_d = ST_JUMP;
                    OPC_JAL:        state_d = ST_JAL;
                    OPC_ADDI:       state_d = ST_ADDI_EX;
                    OPC_SLTI:       state_d = ST_SLTI_EX;
                    default:        state_d = ST_NOP;
                endcase
            end
            ST_MEM_ADDR: begin
                if (bus.opc == OPC_LW) begin
                    state_d = ST_MEM_READ;
                end else if (bus.opc == OPC_SW) begin
                    state_d = ST_MEM_WRITE;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_MEM_READ: state_d = ST_MEM_WB;
            ST_R_EX:     state_d = ST_R_WB;
            ST_ADDI_EX,
            ST_SLTI_EX:  state_d = ST_I_WB;
            default:     state_d = ST_FETCH;
        endcase
    end

    mc_ctrl_outdec u_outdec (
        .state (state_q),
        .ctrl  (ctrl)
    );

    assign bus.PCWrite        = ctrl.pc_write;
    assign bus.PCWriteCondBeq = ctrl.pc_write_beq;
    assign bus.PCWriteCondBne = ctrl.pc_write_bne;
    assign bus.IorD           = ctrl.i_or_d;
    assign bus.IRWrite        = ctrl.ir_write;
    assign bus.MemRead        = ctrl.mem_read;
    assign bus.MemWrite       = ctrl.mem_write;
    assign bus.RegWrite       = ctrl.reg_write;
    assign bus.RegDst         = ctrl.reg_dst;
    assign bus.JalSig1        = ctrl.jal_sig1;
    assign bus.JalSig2        = ctrl.jal_sig2;
    assign bus.MemToReg       = ctrl.mem_to_reg;
    assign bus.ALUSrcA        = ctrl.alu_src_a;
    assign bus.ALUSrcB        = ctrl.alu_src_b;
    assign bus.ALUOp          = ctrl.alu_op;
    assign bus.PCSrc          = ctrl.pc_src;
    assign bus.done           = ctrl.done;

endmodule
`default_nettype wire

// File: tb/tb_mc_control_fsm.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_mc_control_fsm
//  Description : Scoreboard bench for the multi-cycle MIPS controller.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mc_control_fsm;

    // Field order: PCWrite CondBeq CondBne IorD IRWrite MemRead MemWrite
    //              RegWrite RegDst JalSig1 JalSig2 MemToReg ALUSrcA | SrcB | ALUOp | PCSrc | done
    localparam logic [19:0] V_FETCH  = {13'b1_0_0_0_1_1_0_0_0_0_0_0_0, 2'b01, 2'b00, 2'b00, 1'b0};
    localparam logic [19:0] V_DECODE = {13'b0_0_0_0_0_0_0_0_0_0_0_0_0, 2'b11, 2'b00, 2'b00, 1'b0};
    localparam logic [19:0] V_MADDR  = {13'b0_0_0_0_0_0_0_0_0_0_0_0_1, 2'b10, 2'b00, 2'b00, 1'b0};
    localparam logic [19:0] V_MREAD  = {13'b0_0_0_1_0_1_0_0_0_0_0_0_0, 2'b00, 2'b00, 2'b00, 1'b0};
    localparam logic [19:0] V_MWB    = {13'b0_0_0_0_0_0_0_1_0_0_0_1_0, 2'b00, 2'b00, 2'b00, 1'b1};
    localparam logic [19:0] V_MWRITE = {13'b0_0_0_1_0_0_1_0_0_0_0_0_0, 2'b00, 2'b00, 2'b00, 1'b1};
    localparam logic [19:0] V_REX    = {13'b0_0_0_0_0_0_0_0_0_0_0_0_1, 2'b00, 2'b10, 2'b00, 1'b0};
    localparam logic [19:0] V_RWB    = {13'b0_0_0_0_0_0_0_1_1_0_0_0_0, 2'b00, 2'b00, 2'b00, 1'b1};
    localparam logic [19:0] V_BEQ    = {13'b0_1_0_0_0_0_0_0_0_0_0_0_1, 2'b00, 2'b01, 2'b01, 1'b1};
    localparam logic [19:0] V_BNE    = {13'b0_0_1_0_0_0_0_0_0_0_0_0_1, 2'b00, 2'b01, 2'b01, 1'b1};
    localparam logic [19:0] V_JUMP   = {13'b1_0_0_0_0_0_0_0_0_0_0_0_0, 2'b00, 2'b00, 2'b10, 1'b1};
    localparam logic [19:0] V_JAL    = {13'b1_0_0_0_0_0_0_1_0_1_1_0_0, 2'b00, 2'b00, 2'b10, 1'b1};
    localparam logic [19:0] V_ADDI   = {13'b0_0_0_0_0_0_0_0_0_0_0_0_1, 2'b10, 2'b00, 2'b00, 1'b0};
    localparam logic [19:0] V_SLTI   = {13'b0_0_0_0_0_0_0_0_0_0_0_0_1, 2'b10, 2'b11, 2'b00, 1'b0};
    localparam logic [19:0] V_IWB    = {13'b0_0_0_0_0_0_0_1_0_0_0_0_0, 2'b00, 2'b00, 2'b00, 1'b1};
    localparam logic [19:0] V_NOP    = {13'b0_0_0_0_0_0_0_0_0_0_0_0_0, 2'b00, 2'b00, 2'b00, 1'b1};

    localparam logic [5:0] C_R    = 6'b000000;
    localparam logic [5:0] C_LW   = 6'b100011;
    localparam logic [5:0] C_SW   = 6'b101011;
    localparam logic [5:0] C_BEQ  = 6'b000100;
    localparam logic [5:0] C_BNE  = 6'b000101;
    localparam logic [5:0] C_J    = 6'b000010;
    localparam logic [5:0] C_JAL  = 6'b000011;
    localparam logic [5:0] C_ADDI = 6'b001000;
    localparam logic [5:0] C_SLTI = 6'b001010;

    typedef struct {
        logic [19:0] v;
        string       tag;
    } exp_t;

    logic        clk;
    logic        rst;
    exp_t        sb_q[$];
    exp_t        e;
    int          n_vec;
    int          n_err;
    int          done_cnt;
    logic        cnt_en;
    logic [19:0] act;
    logic [5:0]  ops[9];

    mc_control_fsm_if u_if ();

    mc_control_fsm dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if.master)
    );

    assign act = {u_if.PCWrite, u_if.PCWriteCondBeq, u_if.PCWriteCondBne, u_if.IorD,
                  u_if.IRWrite, u_if.MemRead, u_if.MemWrite, u_if.RegWrite, u_if.RegDst,
                  u_if.JalSig1, u_if.JalSig2, u_if.MemToReg, u_if.ALUSrcA,
                  u_if.ALUSrcB, u_if.ALUOp, u_if.PCSrc, u_if.done};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: one expected control vector per cycle, sampled mid-cycle.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            n_vec++;
            if (act !== e.v) begin
                n_err++;
                $display("FAIL %s: got %b want %b", e.tag, act, e.v);
            end
        end
        if (cnt_en && u_if.done === 1'b1) done_cnt++;
    end

    task automatic push(input logic [19:0] v, input string tag);
        exp_t x;
        x.v   = v;
        x.tag = tag;
        sb_q.push_back(x);
    endtask

    task automatic push_instr(input logic [5:0] op, input string nm, output int n);
        push(V_FETCH,  {nm, ".fetch"});
        push(V_DECODE, {nm, ".decode"});
        case (op)
            C_LW:   begin push(V_MADDR, {nm, ".addr"}); push(V_MREAD, {nm, ".rd"});
                          push(V_MWB, {nm, ".wb"}); n = 5; end
            C_SW:   begin push(V_MADDR, {nm, ".addr"}); push(V_MWRITE, {nm, ".wr"}); n = 4; end
            C_R:    begin push(V_REX, {nm, ".ex"}); push(V_RWB, {nm, ".wb"}); n = 4; end
            C_BEQ:  begin push(V_BEQ, {nm, ".br"}); n = 3; end
            C_BNE:  begin push(V_BNE, {nm, ".br"}); n = 3; end
            C_J:    begin push(V_JUMP, {nm, ".j"}); n = 3; end
            C_JAL:  begin push(V_JAL, {nm, ".jal"}); n = 3; end
            C_ADDI: begin push(V_ADDI, {nm, ".ex"}); push(V_IWB, {nm, ".wb"}); n = 4; end
            C_SLTI: begin push(V_SLTI, {nm, ".ex"}); push(V_IWB, {nm, ".wb"}); n = 4; end
            default: begin push(V_NOP, {nm, ".nop"}); n = 3; end
        endcase
    endtask

    // Called just after a rising edge that leaves the FSM in FETCH.
    task automatic run_instr(input logic [5:0] op, input string nm);
        int n;
        u_if.opc = op;
        push_instr(op, nm, n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic run_lw_abort();
        u_if.opc = C_LW;
        push(V_FETCH,  "abort.fetch");
        push(V_DECODE, "abort.decode");
        push(V_MADDR,  "abort.addr");
        push(V_MREAD,  "abort.rd");
        repeat (3) @(posedge clk);
        #7;
        rst = 1'b0;
        #1;
        n_vec++;
        if (act !== V_FETCH) begin
            n_err++;
            $display("FAIL abort.async: got %b want %b", act, V_FETCH);
        end
        @(posedge clk);
        #1;
        n_vec++;
        if (act !== V_FETCH) begin
            n_err++;
            $display("FAIL abort.hold: got %b want %b", act, V_FETCH);
        end
        rst = 1'b1;
    endtask

    initial begin
        n_vec    = 0;
        n_err    = 0;
        done_cnt = 0;
        cnt_en   = 1'b0;
        ops = '{C_R, C_LW, C_SW, C_BEQ, C_BNE, C_J, C_JAL, C_ADDI, C_SLTI};
        rst      = 1'b1;
        u_if.opc = C_LW;
        #2;
        rst = 1'b0;
        push(V_FETCH, "reset.a");
        push(V_FETCH, "reset.b");
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;

        run_instr(C_LW,      "lw");
        run_instr(C_SW,      "sw");
        run_instr(C_R,       "rtype");
        run_instr(C_BEQ,     "beq");
        run_instr(C_BNE,     "bne");
        run_instr(C_JAL,     "jal");
        run_instr(C_J,       "j");
        run_instr(C_ADDI,    "addi");
        run_instr(C_SLTI,    "slti");
        run_instr(6'b111111, "nop");
        run_lw_abort();
        run_instr(C_LW,      "lw_after_abort");

        cnt_en   = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 1000; i++) begin
            int unsigned idx;
            logic [5:0]  op;
            idx = $urandom_range(0, 9);
            if (idx < 9) op = ops[idx];
            else         op = 6'($urandom_range(0, 63));
            run_instr(op, "rand");
        end
        @(negedge clk);
        cnt_en = 1'b0;
        n_vec++;
        if (done_cnt != 1000) begin
            n_err++;
            $display("FAIL done_count: got %0d want %0d", done_cnt, 1000);
        end

        n_vec++;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d left want %0d", sb_q.size(), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
